memory_dual_port: RTL and testbench

MEMORY_DUAL_PORT -- requirements
Module: memory_dual_port

---
 rtl/mem_pkg.sv | 26 ++
 rtl/mem_array_2r1w.sv | 28 ++
 rtl/memory_dual_port.sv | 191 +++++++++++++++++++
 tb/tb_memory_dual_port.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types, default sizes and index-width helper for the dual-port memory.
package mem_pkg;

  // Two-state controller: clear the array after reset, then serve accesses.
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } mem_state_e;

  localparam int unsigned MEM_DATA_W_DEF = 32'd16;
  localparam int unsigned MEM_ADDR_W_DEF = 32'd16;
  localparam int unsigned MEM_DEPTH_DEF  = 32'd1024;

  // Number of index bits needed to address 'depth' words (ceil(log2)).
  function automatic int unsigned log2_idx(input int unsigned depth);
    int unsigned w;
    w = 32'd0;
    for (int unsigned i = 32'd0; i < 32'd32; i++) begin
      if ((33'd1 << i) < {1'b0, depth}) begin
        w = i + 32'd1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/mem_array_2r1w.sv
// Storage array: one write port, two synchronous read-first read ports.
module mem_array_2r1w #(
  parameter int unsigned DATA_W = 32'd16,
  parameter int unsigned DEPTH  = 32'd1024,
  parameter int unsigned IDX_W  = 32'd10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr_a,
  output logic [DATA_W-1:0] q_a,
  input  logic [IDX_W-1:0]  raddr_b,
  output logic [DATA_W-1:0] q_b
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Write the array; reads see the pre-write word because of non-blocking update.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
    q_a <= mem_r[raddr_a];
    q_b <= mem_r[raddr_b];
  end

endmodule

// File: rtl/memory_dual_port.sv
// Dual-port memory: text read port plus data read/write port, post-reset clear,
// optional address range faulting and write-first bypass on the data port.
module memory_dual_port
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W         = MEM_DATA_W_DEF,
  parameter int unsigned ADDR_W         = MEM_ADDR_W_DEF,
  parameter int unsigned DEPTH          = MEM_DEPTH_DEF,
  parameter bit          WRAP           = 1'b1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_q,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_data,
  input  logic              d_we,
  output logic [DATA_W-1:0] d_q,
  output logic              busy,
  output logic              fault,
  output logic [ADDR_W-1:0] fault_addr
);

  localparam int unsigned     IDX_W    = log2_idx(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 32'd1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(32'd1);

  mem_state_e        state_r;
  mem_state_e        state_nxt_s;
  logic [IDX_W-1:0]  cnt_r;
  logic [IDX_W-1:0]  cnt_nxt_s;

  logic              ready_s;
  logic [IDX_W-1:0]  i_idx_s;
  logic [IDX_W-1:0]  d_idx_s;
  logic              i_oob_s;
  logic              d_oob_s;
  logic              fault_hit_s;

  logic              arr_we_s;
  logic [IDX_W-1:0]  arr_waddr_s;
  logic [DATA_W-1:0] arr_wdata_s;
  logic [DATA_W-1:0] arr_i_q_s;
  logic [DATA_W-1:0] arr_d_q_s;

  logic              i_zero_r;
  logic              d_zero_r;
  logic              d_byp_r;
  logic [DATA_W-1:0] d_byp_data_r;
  logic              fault_r;
  logic [ADDR_W-1:0] fault_addr_r;

  assign ready_s = (state_r == ST_READY);
  assign i_idx_s = i_addr[IDX_W-1:0];
  assign d_idx_s = d_addr[IDX_W-1:0];

  // Range check: in wrap mode every address aliases onto the low index bits.
  always_comb begin
    i_oob_s = 1'b0;
    d_oob_s = 1'b0;
    if (!WRAP) begin
      i_oob_s = ({1'b0, i_addr} >= DEPTH_X);
      d_oob_s = ({1'b0, d_addr} >= DEPTH_X);
    end else begin
      i_oob_s = 1'b0;
      d_oob_s = 1'b0;
    end
    fault_hit_s = ready_s & (i_oob_s | d_oob_s);
  end

  // Next-state logic: walk the clear counter to the last index, then serve.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_CLEAR: begin
        cnt_nxt_s = cnt_r + IDX_ONE;
        if (cnt_r == LAST_IDX) begin
          state_nxt_s = ST_READY;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      ST_READY: begin
        state_nxt_s = ST_READY;
        cnt_nxt_s   = cnt_r;
      end
      default: begin
        state_nxt_s = ST_CLEAR;
        cnt_nxt_s   = {IDX_W{1'b0}};
      end
    endcase
  end

  // State register; reset restarts the clear sequence from index 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      cnt_r   <= {IDX_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Write port mux: clear writes zeros, otherwise the data port writes when legal.
  always_comb begin
    arr_we_s    = 1'b0;
    arr_waddr_s = {IDX_W{1'b0}};
    arr_wdata_s = {DATA_W{1'b0}};
    if (state_r == ST_CLEAR) begin
      arr_we_s    = ~reset;
      arr_waddr_s = cnt_r;
      arr_wdata_s = {DATA_W{1'b0}};
    end else begin
      arr_we_s    = ~reset & d_we & ~d_oob_s;
      arr_waddr_s = d_idx_s;
      arr_wdata_s = d_data;
    end
  end

  mem_array_2r1w #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .we      (arr_we_s),
    .waddr   (arr_waddr_s),
    .wdata   (arr_wdata_s),
    .raddr_a (i_idx_s),
    .q_a     (arr_i_q_s),
    .raddr_b (d_idx_s),
    .q_b     (arr_d_q_s)
  );

  // Read-side qualifiers: force zero while clearing or after an out-of-range read,
  // and remember a same-cycle data write so it can bypass the read-first array.
  always_ff @(posedge clk) begin
    if (reset) begin
      i_zero_r     <= 1'b1;
      d_zero_r     <= 1'b1;
      d_byp_r      <= 1'b0;
      d_byp_data_r <= {DATA_W{1'b0}};
    end else begin
      i_zero_r     <= ~ready_s | i_oob_s;
      d_zero_r     <= ~ready_s | d_oob_s;
      d_byp_r      <= ready_s & d_we & ~d_oob_s;
      d_byp_data_r <= d_data;
    end
  end

  // Sticky fault flag; only the first faulting address is kept, data port wins ties.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_r      <= 1'b0;
      fault_addr_r <= {ADDR_W{1'b0}};
    end else if (fault_hit_s && !fault_r) begin
      fault_r      <= 1'b1;
      fault_addr_r <= d_oob_s ? d_addr : i_addr;
    end else begin
      fault_r      <= fault_r;
      fault_addr_r <= fault_addr_r;
    end
  end

  // Output selection from registered qualifiers and registered array data.
  always_comb begin
    i_q = {DATA_W{1'b0}};
    d_q = {DATA_W{1'b0}};
    if (i_zero_r) begin
      i_q = {DATA_W{1'b0}};
    end else begin
      i_q = arr_i_q_s;
    end
    if (d_zero_r) begin
      d_q = {DATA_W{1'b0}};
    end else if (d_byp_r) begin
      d_q = d_byp_data_r;
    end else begin
      d_q = arr_d_q_s;
    end
  end

  assign busy       = (state_r == ST_CLEAR);
  assign fault      = fault_r;
  assign fault_addr = fault_addr_r;

endmodule

// File: tb/tb_memory_dual_port.sv
// Directed self-checking bench: default (wrap) instance plus a fault-mode instance.
module tb_memory_dual_port;

  logic        clk;
  logic        reset;
  logic [15:0] i_addr, d_addr, d_data;
  logic        d_we;
  logic [15:0] i_q, d_q, fault_addr;
  logic        busy, fault;

  logic [15:0] n_i_addr, n_d_addr, n_d_data;
  logic        n_d_we;
  logic [15:0] n_i_q, n_d_q, n_fault_addr;
  logic        n_busy, n_fault;

  int errs;
  int checks;

  memory_dual_port dut (
    .clk(clk), .reset(reset),
    .i_addr(i_addr), .i_q(i_q),
    .d_addr(d_addr), .d_data(d_data), .d_we(d_we), .d_q(d_q),
    .busy(busy), .fault(fault), .fault_addr(fault_addr)
  );

  memory_dual_port #(.WRAP(1'b0)) dut_nw (
    .clk(clk), .reset(reset),
    .i_addr(n_i_addr), .i_q(n_i_q),
    .d_addr(n_d_addr), .d_data(n_d_data), .d_we(n_d_we), .d_q(n_d_q),
    .busy(n_busy), .fault(n_fault), .fault_addr(n_fault_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Counts cycles with busy high on both instances, bounded.
  task automatic count_busy(output int c1, output int c2, output bit q_seen);
    int guard;
    c1 = 0; c2 = 0; guard = 0; q_seen = 1'b0;
    while ((busy === 1'b1 || n_busy === 1'b1) && guard < 3000) begin
      if (busy === 1'b1) c1++;
      if (n_busy === 1'b1) c2++;
      if (i_q !== 16'h0000 || d_q !== 16'h0000) q_seen = 1'b1;
      step();
      guard++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c1, c2;
    bit q_seen;
    logic [15:0] rd_addrs [3];
    errs = 0; checks = 0;
    rd_addrs[0] = 16'h0000; rd_addrs[1] = 16'h0200; rd_addrs[2] = 16'h03FF;

    reset = 1'b1;
    i_addr = 16'h0000; d_addr = 16'h0000; d_data = 16'h0000; d_we = 1'b0;
    n_i_addr = 16'h0000; n_d_addr = 16'h0000; n_d_data = 16'h0000; n_d_we = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    check_val("rst_i_q", i_q, 16'h0000);
    check_val("rst_d_q", d_q, 16'h0000);
    check_val("rst_fault", fault, 1'b0);
    check_val("rst_fault_addr", fault_addr, 16'h0000);
    check_val("rst_busy", busy, 1'b1);

    count_busy(c1, c2, q_seen);
    check_val("busy_cycles", c1, 1024);
    check_val("busy_cycles_nw", c2, 1024);
    check_val("q_zero_in_clear", q_seen, 1'b0);

    foreach (rd_addrs[k]) begin
      i_addr = rd_addrs[k]; d_addr = rd_addrs[k];
      step();
      check_val($sformatf("clr_i_q_%0h", rd_addrs[k]), i_q, 16'h0000);
      check_val($sformatf("clr_d_q_%0h", rd_addrs[k]), d_q, 16'h0000);
    end

    // Same-cycle write and text read: write-first on d, read-first on i.
    d_addr = 16'h0000; d_data = 16'h1111; d_we = 1'b1; i_addr = 16'h0000;
    step();
    check_val("wf_d_q", d_q, 16'h1111);
    check_val("rf_i_q_old", i_q, 16'h0000);
    d_we = 1'b0;
    step();
    check_val("rf_i_q_new", i_q, 16'h1111);
    check_val("d_q_after", d_q, 16'h1111);

    // Write enable low must not store.
    d_addr = 16'h0002; d_data = 16'h2222; d_we = 1'b0;
    step();
    step();
    check_val("we0_no_store", d_q, 16'h0000);
    d_data = 16'h3333; d_we = 1'b1;
    step();
    check_val("we1_bypass", d_q, 16'h3333);
    d_we = 1'b0;
    step();
    check_val("we1_stored", d_q, 16'h3333);

    // Aliasing in wrap mode.
    d_addr = 16'h03FF; d_data = 16'h4444; d_we = 1'b1;
    step();
    d_we = 1'b0; d_addr = 16'hFFFF; i_addr = 16'hFFFF;
    step();
    check_val("alias_i_q", i_q, 16'h4444);
    check_val("alias_d_q", d_q, 16'h4444);
    check_val("alias_fault", fault, 1'b0);
    d_addr = 16'h0555; d_data = 16'hA5A5; d_we = 1'b1; i_addr = 16'h0155;
    step();
    d_we = 1'b0;
    step();
    check_val("alias2_i_q", i_q, 16'hA5A5);
    check_val("alias_fault2", fault, 1'b0);

    // Fault mode instance.
    n_d_addr = 16'h0000; n_d_data = 16'h0ABC; n_d_we = 1'b1;
    step();
    check_val("nw_pre_fault", n_fault, 1'b0);
    n_d_addr = 16'h0400; n_d_data = 16'h5555; n_d_we = 1'b1;
    step();
    check_val("nw_oob_d_q", n_d_q, 16'h0000);
    check_val("nw_fault", n_fault, 1'b1);
    check_val("nw_fault_addr", n_fault_addr, 16'h0400);
    n_d_we = 1'b0; n_d_addr = 16'h0000; n_i_addr = 16'h0000;
    step();
    check_val("nw_word0_d", n_d_q, 16'h0ABC);
    check_val("nw_word0_i", n_i_q, 16'h0ABC);
    n_i_addr = 16'h0800;
    step();
    check_val("nw_oob_i_q", n_i_q, 16'h0000);
    check_val("nw_fault_sticky", n_fault, 1'b1);
    check_val("nw_fault_addr_first", n_fault_addr, 16'h0400);
    n_i_addr = 16'h0000;

    // Reset mid-clear restarts the full sequence; writes during clear are ignored.
    reset = 1'b1;
    step();
    reset = 1'b0;
    d_addr = 16'h0005; d_data = 16'hFFFF; d_we = 1'b1;
    repeat (500) step();
    check_val("mid_clear_busy", busy, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    count_busy(c1, c2, q_seen);
    d_we = 1'b0;
    check_val("restart_busy_cycles", c1, 1024);
    check_val("restart_busy_cycles_nw", c2, 1024);
    check_val("restart_q_zero", q_seen, 1'b0);
    check_val("restart_fault", fault, 1'b0);
    check_val("restart_fault_nw", n_fault, 1'b0);
    check_val("restart_fault_addr_nw", n_fault_addr, 16'h0000);
    step();
    check_val("clear_ignored_we", d_q, 16'h0000);

    // Both ports out of range in one cycle: data address is captured.
    n_i_addr = 16'h0900; n_d_addr = 16'h0A00;
    step();
    check_val("both_fault", n_fault, 1'b1);
    check_val("both_fault_addr", n_fault_addr, 16'h0A00);
    check_val("both_i_q", n_i_q, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
